// File: rtl/traffic_phase_ctrl_if.sv
// Lamp/display/request bundle between the phase controller and its surroundings.
// The controller is the slave: it takes requests and drives lamps and display.
interface traffic_phase_ctrl_if;
   logic       ped_req;
   logic       night;
   logic [5:0] value;
   logic       blank;
   logic [2:0] ns_lamp;
   logic [2:0] ew_lamp;
   logic       tick;

   modport master (
      output ped_req, night,
      input  value, blank, ns_lamp, ew_lamp, tick
   );

   modport slave (
      input  ped_req, night,
      output value, blank, ns_lamp, ew_lamp, tick
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase controller: 1 Hz divider, request synchronizers,
// phase FSM with pedestrian green cut and night flash, registered lamp/display outputs.
module traffic_phase_ctrl #(
   parameter int CLK_HZ    = 50000000,
   parameter int GREEN_S   = 25,
   parameter int YELLOW_S  = 3,
   parameter int RED_CLR_S = 2,
   parameter int PED_CUT_S = 5
) (
   input  logic                clk,
   input  logic                rst,
   traffic_phase_ctrl_if.slave bus
);
   typedef enum logic [2:0] {AR1, NS_G, NS_Y, AR2, EW_G, EW_Y, FLASH} state_t;

   localparam int               DIV_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
   localparam logic [5:0]       GREEN_D = 6'(GREEN_S);
   localparam logic [5:0]       YEL_D   = 6'(YELLOW_S);
   localparam logic [5:0]       RED_D   = 6'(RED_CLR_S);
   localparam logic [5:0]       CUT_D   = 6'(PED_CUT_S);

   logic [DIV_W-1:0] div_reg, div_next;
   logic             tick_reg;
   logic             ped_s1_reg, ped_s2_reg, ped_s3_reg;
   logic             night_s1_reg, night_s2_reg;
   logic             ped_rise;
   logic             ped_pend_reg, ped_pend_next;
   state_t           state_reg, state_next;
   logic [5:0]       remain_reg, remain_next;
   logic             flash_ph_reg, flash_ph_next;
   logic [2:0]       ns_next, ew_next;
   logic [5:0]       value_reg;
   logic             blank_reg;
   logic [2:0]       ns_reg, ew_reg;

   assign div_next = (div_reg == DIV_MAX) ? '0 : div_reg + 1'b1;
   assign ped_rise = ped_s2_reg & ~ped_s3_reg;

   // Divider; tick is registered so it is high exactly while the count sits at CLK_HZ-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         div_reg  <= div_next;
         tick_reg <= (div_next == DIV_MAX);
      end
   end

   // Two-flop synchronizers; the third ped flop only serves the rising-edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ped_s1_reg   <= 1'b0;
         ped_s2_reg   <= 1'b0;
         ped_s3_reg   <= 1'b0;
         night_s1_reg <= 1'b0;
         night_s2_reg <= 1'b0;
      end else begin
         ped_s1_reg   <= bus.ped_req;
         ped_s2_reg   <= ped_s1_reg;
         ped_s3_reg   <= ped_s2_reg;
         night_s1_reg <= bus.night;
         night_s2_reg <= night_s1_reg;
      end
   end

   // Phase state and output registers; outputs load from the next-state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= AR1;
         remain_reg   <= RED_D;
         flash_ph_reg <= 1'b0;
         ped_pend_reg <= 1'b0;
         value_reg    <= RED_D;
         blank_reg    <= 1'b0;
         ns_reg       <= 3'b100;
         ew_reg       <= 3'b100;
      end else begin
         state_reg    <= state_next;
         remain_reg   <= remain_next;
         flash_ph_reg <= flash_ph_next;
         ped_pend_reg <= ped_pend_next;
         value_reg    <= remain_next;
         blank_reg    <= (state_next == FLASH);
         ns_reg       <= ns_next;
         ew_reg       <= ew_next;
      end
   end

   // Next-state, countdown, pedestrian flag and lamp decode; nothing moves between ticks.
   always_comb begin
      state_next    = state_reg;
      remain_next   = remain_reg;
      flash_ph_next = flash_ph_reg;
      ped_pend_next = ped_pend_reg;
      ns_next       = 3'b100;
      ew_next       = 3'b100;

      if (tick_reg) begin
         if (state_reg == FLASH) begin
            if (night_s2_reg) begin
               flash_ph_next = ~flash_ph_reg;
            end else begin
               state_next    = AR1;
               remain_next   = RED_D;
               flash_ph_next = 1'b0;
            end
         end else if (remain_reg == 6'd1) begin
            if ((state_reg == AR1 || state_reg == AR2) && night_s2_reg) begin
               state_next    = FLASH;
               remain_next   = 6'd0;
               flash_ph_next = 1'b1;
            end else begin
               case (state_reg)
                  AR1:     begin state_next = NS_G; remain_next = GREEN_D; end
                  NS_G:    begin state_next = NS_Y; remain_next = YEL_D;   end
                  NS_Y:    begin state_next = AR2;  remain_next = RED_D;   end
                  AR2:     begin state_next = EW_G; remain_next = GREEN_D; end
                  EW_G:    begin state_next = EW_Y; remain_next = YEL_D;   end
                  default: begin state_next = AR1;  remain_next = RED_D;   end
               endcase
               // Any pending request is served (or moot) once green ends.
               if (state_next == NS_Y || state_next == EW_Y) begin
                  ped_pend_next = 1'b0;
               end
            end
         end else if (ped_pend_reg && (state_reg == NS_G || state_reg == EW_G) &&
                      (remain_reg > CUT_D)) begin
            remain_next = CUT_D;
         end else begin
            remain_next = remain_reg - 6'd1;
         end
      end

      // A new request wins over a same-cycle clear.
      if (ped_rise) begin
         ped_pend_next = 1'b1;
      end

      case (state_next)
         NS_G:    ns_next = 3'b001;
         NS_Y:    ns_next = 3'b010;
         EW_G:    ew_next = 3'b001;
         EW_Y:    ew_next = 3'b010;
         FLASH: begin
            ns_next = flash_ph_next ? 3'b010 : 3'b000;
            ew_next = flash_ph_next ? 3'b010 : 3'b000;
         end
         default: ;
      endcase
   end

   assign bus.value   = value_reg;
   assign bus.blank   = blank_reg;
   assign bus.ns_lamp = ns_reg;
   assign bus.ew_lamp = ew_reg;
   assign bus.tick    = tick_reg;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: phase-table reference model feeds an expectation
// queue on every tick and on reset; a negedge monitor pops and compares.
module tb_traffic_phase_ctrl;
   localparam int CLK_HZ    = 10;
   localparam int GREEN_S   = 25;
   localparam int YELLOW_S  = 3;
   localparam int RED_CLR_S = 2;
   localparam int PED_CUT_S = 5;
   localparam int PH_FLASH  = 6;

   typedef struct {
      int         id;
      logic [5:0] value;
      logic       blank;
      logic [2:0] ns;
      logic [2:0] ew;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   traffic_phase_ctrl_if bus();

   traffic_phase_ctrl #(
      .CLK_HZ(CLK_HZ), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S),
      .RED_CLR_S(RED_CLR_S), .PED_CUT_S(PED_CUT_S)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb_q[$];
   int   txn_id = 0;

   // Reference model state: phase index into the fixed cycle
   // 0 AR1, 1 NS_G, 2 NS_Y, 3 AR2, 4 EW_G, 5 EW_Y, 6 flash.
   int   m_ph = 0, m_rem = RED_CLR_S, m_fph = 0, m_pend = 0, m_cyc = 0;
   bit   p1, p2, p3, n1, n2;
   bit   exp_tick = 1'b0;

   function automatic int dur_of(input int ph);
      case (ph)
         1, 4:    return GREEN_S;
         2, 5:    return YELLOW_S;
         default: return RED_CLR_S;
      endcase
   endfunction

   function automatic logic [2:0] ns_of(input int ph, input int fph);
      case (ph)
         1:        return 3'b001;
         2:        return 3'b010;
         PH_FLASH: return (fph != 0) ? 3'b010 : 3'b000;
         default:  return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] ew_of(input int ph, input int fph);
      case (ph)
         4:        return 3'b001;
         5:        return 3'b010;
         PH_FLASH: return (fph != 0) ? 3'b010 : 3'b000;
         default:  return 3'b100;
      endcase
   endfunction

   task automatic push_expect();
      exp_t e;
      e.id    = txn_id;
      e.value = 6'(m_rem);
      e.blank = (m_ph == PH_FLASH);
      e.ns    = ns_of(m_ph, m_fph);
      e.ew    = ew_of(m_ph, m_fph);
      sb_q.push_back(e);
      txn_id++;
   endtask

   // Reference model: one step per clock edge, one expectation per tick or reset.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_ph = 0; m_rem = RED_CLR_S; m_fph = 0; m_pend = 0; m_cyc = 0;
            p1 = 0; p2 = 0; p3 = 0; n1 = 0; n2 = 0;
            exp_tick = 1'b0;
            push_expect();
         end else begin
            bit tick_b, set_b;
            tick_b = ((m_cyc % CLK_HZ) == CLK_HZ - 1);
            set_b  = p2 && !p3;
            if (tick_b) begin
               if (m_ph == PH_FLASH) begin
                  if (n2) m_fph = 1 - m_fph;
                  else begin m_ph = 0; m_rem = RED_CLR_S; m_fph = 0; end
               end else if (m_rem == 1) begin
                  if ((m_ph == 0 || m_ph == 3) && n2) begin
                     m_ph = PH_FLASH; m_rem = 0; m_fph = 1;
                  end else begin
                     m_ph  = (m_ph + 1) % 6;
                     m_rem = dur_of(m_ph);
                     if (m_ph == 2 || m_ph == 5) m_pend = 0;
                  end
               end else if (m_pend != 0 && (m_ph == 1 || m_ph == 4) && m_rem > PED_CUT_S) begin
                  m_rem = PED_CUT_S;
               end else begin
                  m_rem = m_rem - 1;
               end
            end
            if (set_b) m_pend = 1;
            m_cyc++;
            exp_tick = ((m_cyc % CLK_HZ) == CLK_HZ - 1);
            p3 = p2; p2 = p1; p1 = bus.ped_req;
            n2 = n1; n1 = bus.night;
            if (tick_b) push_expect();
         end
      end
   end

   // Monitor: tick checked every cycle, lamp/display state on each queued transaction.
   initial begin
      forever begin
         @(negedge clk);
         compared++;
         if (bus.tick !== exp_tick) begin
            mismatched++;
            $display("FAIL tick at %0t: got %b want %b", $time, bus.tick, exp_tick);
         end
         compared++;
         assert (!(bus.ns_lamp[0] === 1'b1 && bus.ew_lamp[0] === 1'b1))
         else begin
            mismatched++;
            $error("FAIL both_green at %0t: ns=%03b ew=%03b want no double green",
                   $time, bus.ns_lamp, bus.ew_lamp);
         end
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            compared++;
            if (bus.value !== e.value || bus.blank !== e.blank ||
                bus.ns_lamp !== e.ns || bus.ew_lamp !== e.ew) begin
               mismatched++;
               $display("FAIL txn%0d outputs: got value=%0d blank=%b ns=%03b ew=%03b want value=%0d blank=%b ns=%03b ew=%03b",
                        e.id, bus.value, bus.blank, bus.ns_lamp, bus.ew_lamp,
                        e.value, e.blank, e.ns, e.ew);
            end else begin
               $display("txn%0d ok: value=%0d blank=%b ns=%03b ew=%03b",
                        e.id, bus.value, bus.blank, bus.ns_lamp, bus.ew_lamp);
            end
         end
      end
   end

   // Wait (bounded) until the reference model reaches a phase/remaining pair.
   task automatic wait_model(input int wph, input int wrem, input int budget, input string what);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_ph == wph && (wrem < 0 || m_rem == wrem)) && n < budget);
      if (!(m_ph == wph && (wrem < 0 || m_rem == wrem))) begin
         compared++;
         mismatched++;
         $display("FAIL wait_%s: got phase=%0d remain=%0d want phase=%0d remain=%0d",
                  what, m_ph, m_rem, wph, wrem);
      end
   endtask

   task automatic pulse_ped();
      bus.ped_req = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      bus.ped_req = 1'b0;
   endtask

   // Stimulus: directed walk through the phase cycle, then randomized requests.
   initial begin
      bus.ped_req = 1'b0;
      bus.night   = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      wait_model(1, GREEN_S, 40, "ns_g_entry");
      repeat (60 * CLK_HZ) @(negedge clk);

      wait_model(1, 20, 800, "ns_g_20");
      pulse_ped();
      wait_model(2, YELLOW_S, 400, "ns_y_after_cut");

      wait_model(1, 4, 1000, "ns_g_4");
      pulse_ped();
      wait_model(3, -1, 200, "ar2");
      pulse_ped();
      wait_model(4, PED_CUT_S, 200, "ew_g_cut");

      wait_model(4, 12, 1000, "ew_g_12");
      bus.night = 1'b1;
      wait_model(PH_FLASH, -1, 500, "flash");
      repeat (5 * CLK_HZ) @(negedge clk);
      bus.night = 1'b0;
      wait_model(0, RED_CLR_S, 100, "flash_exit");

      wait_model(5, 2, 1000, "ew_y");
      repeat ($urandom_range(1, 8)) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #10 rst = 1'b0;

      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         bus.ped_req = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 599) == 0) bus.night = ~bus.night;
      end
      bus.ped_req = 1'b0;
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
